// File: rtl/pool2d_stream.sv
// Streaming KxK pooling (average or max) of signed pixels, row-major, one pixel per cycle.
// Latency: pooled value is registered on the edge that accepts the window-closing pixel.
// Backpressure: in_ready drops while a pooled value is held and out_ready is low; nothing is lost.
module pool2d_stream #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 16,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int POOL_K = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy,
  output logic              finished_pool
);

  localparam int LK   = $clog2(POOL_K);
  localparam int NENT = IMG_W / POOL_K;
  localparam int CW   = $clog2(IMG_W);
  localparam int RW   = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
  // POOL_K is a power of two, so K-1 is all ones in the low LK bits.
  localparam logic [LK-1:0] SUB_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           col;
  logic [RW-1:0]           row;
  logic                    mode_q;
  logic signed [OUT_W-1:0] bank [NENT];

  logic                    accept;
  logic                    win_first;
  logic                    win_last;
  logic                    frame_end;
  logic [CW-LK-1:0]        idx;
  logic signed [OUT_W-1:0] pix_ext;
  logic signed [OUT_W-1:0] acc_cur;
  logic signed [OUT_W-1:0] acc_sum;
  logic signed [OUT_W-1:0] acc_max;
  logic signed [OUT_W-1:0] merged;
  logic signed [OUT_W-1:0] result;

  assign accept = in_valid && in_ready;

  // Window position decode and accumulate/compare datapath for the current pixel.
  always_comb begin
    idx       = col[CW-1:LK];
    win_first = (col[LK-1:0] == '0) && (row[LK-1:0] == '0);
    win_last  = (col[LK-1:0] == SUB_MAX) && (row[LK-1:0] == SUB_MAX);
    frame_end = (col == COL_MAX) && (row == ROW_MAX);
    pix_ext   = {{(OUT_W-DATA_W){in_data[DATA_W-1]}}, in_data};
    acc_cur   = bank[idx];
    acc_sum   = acc_cur + pix_ext;
    acc_max   = (pix_ext > acc_cur) ? pix_ext : acc_cur;
    merged    = mode_q ? acc_max : acc_sum;
    // Arithmetic shift gives floor division of the window sum by K*K.
    result    = mode_q ? acc_max : (acc_sum >>> (2 * LK));
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status decode.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    finished_pool = 1'b0;
    in_ready      = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        busy     = 1'b1;
        in_ready = !out_valid || out_ready;
        if (out_valid && out_ready && out_last) state_nxt = DONE;
      end
      DONE: begin
        finished_pool = 1'b1;
        if (!enable) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pixel counters, accumulator bank and output register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col       <= '0;
      row       <= '0;
      mode_q    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < NENT; i++) bank[i] <= '0;
    end else begin
      if (state == IDLE) begin
        col <= '0;
        row <= '0;
        if (enable) mode_q <= mode;
      end else if (accept) begin
        if (col == COL_MAX) begin
          col <= '0;
          row <= (row == ROW_MAX) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (accept) bank[idx] <= win_first ? pix_ext : merged;

      // A new result can only arrive when the slot is free or being drained this cycle.
      if (accept && win_last) begin
        out_data  <= result;
        out_valid <= 1'b1;
        out_last  <= frame_end;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2d_stream.sv
// Scoreboarded bench for pool2d_stream at default parameters (28x28, K=2).
// Expected pooled values are queued before each frame; a negedge monitor pops on each handshake.
// Covers reset, avg/max frames, rounding corners, backpressure, random out_ready, mid-frame reset.
module tb_pool2d_stream;

  localparam int W    = 28;
  localparam int H    = 28;
  localparam int K    = 2;
  localparam int NW   = W / K;
  localparam int NOUT = (W / K) * (H / K);
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_last;
  logic        busy;
  logic        finished_pool;

  always #5 clk = ~clk;

  pool2d_stream #(
    .DATA_W(8), .OUT_W(16), .IMG_W(W), .IMG_H(H), .POOL_K(K)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .finished_pool(finished_pool)
  );

  typedef struct {
    int data;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_cyc = -10;
  int   n_out = 0;
  int   rdy_mode = 0;
  int   img [NPIX];
  bit   hand_vld [NOUT];
  int   hand_val [NOUT];
  bit   stall_prev = 0;
  int   stall_data = 0;
  int   stall_last = 0;
  bit   ok;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random, 2 = left to the stimulus
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1)      out_ready = 1'($urandom_range(0, 1));
    else if (rdy_mode == 0) out_ready = 1'b1;
  end

  // Monitor: hold-stability while stalled, and scoreboard pop on every handshake
  always @(negedge clk) begin
    if (stall_prev && reset) begin
      chk("hold_valid", int'(out_valid), 1);
      chk("hold_data", int'($signed(out_data)), stall_data);
      chk("hold_last", int'(out_last), stall_last);
    end
    stall_prev = reset && out_valid && !out_ready;
    stall_data = int'($signed(out_data));
    stall_last = int'(out_last);
    if (reset && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=%0d expected=none", int'($signed(out_data)));
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", int'($signed(out_data)), mon_e.data);
        chk("out_last", int'(out_last), int'(mon_e.last));
      end
      if (out_last) last_cyc = cyc;
    end
  end

  function automatic int dig(input int r, input int c);
    if (r >= 6 && r < 22 && c >= 8 && c < 20) return ((r * 5 + c * 11) % 180) - 60;
    return 0;
  endfunction

  task automatic fill_digit();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r * W + c] = dig(r, c);
    for (int w = 0; w < NOUT; w++) hand_vld[w] = 1'b0;
    img[0] = 8;
    hand_vld[0] = 1'b1;
    hand_val[0] = 2;
  endtask

  task automatic set_win(input int w, input int a, input int b, input int c, input int d, input int e);
    int r0, c0;
    r0 = K * (w / NW);
    c0 = K * (w % NW);
    img[r0 * W + c0]           = a;
    img[r0 * W + c0 + 1]       = b;
    img[(r0 + 1) * W + c0]     = c;
    img[(r0 + 1) * W + c0 + 1] = d;
    hand_vld[w] = 1'b1;
    hand_val[w] = e;
  endtask

  task automatic push_expected(input bit m);
    exp_t e;
    int r0, c0, s, q, mx, p;
    for (int w = 0; w < NOUT; w++) begin
      r0 = K * (w / NW);
      c0 = K * (w % NW);
      s  = 0;
      mx = -1000;
      for (int dr = 0; dr < K; dr++)
        for (int dc = 0; dc < K; dc++) begin
          p = img[(r0 + dr) * W + c0 + dc];
          s = s + p;
          if (p > mx) mx = p;
        end
      q = s / 4;
      if (s < 0 && (s % 4) != 0) q = q - 1;
      e.data = hand_vld[w] ? hand_val[w] : (m ? mx : q);
      e.last = (w == NOUT - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_frame(input bit m);
    mode   = m;
    enable = 1'b1;
    n_out  = 0;
    @(posedge clk); #1;
    chk("start_in_ready", int'(in_ready), 1);
    chk("start_busy", int'(busy), 1);
  endtask

  task automatic send_pixels(input int n, output bit good);
    bit acc;
    int t;
    good = 1'b1;
    for (int i = 0; i < n && good; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(img[i]);
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
        t++;
        if (!acc && t > 2000) begin
          good = 1'b0;
          break;
        end
      end
    end
    in_valid = 1'b0;
    if (!good) begin
      checks++;
      failures++;
      $display("FAIL pixel_accept_timeout actual=stalled expected=accepted");
    end
  endtask

  task automatic finish_frame();
    bit seen;
    seen = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (finished_pool) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", int'(seen), 1);
    if (seen) chk("done_latency", cyc, last_cyc + 1);
    chk("out_count", n_out, NOUT);
    chk("queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_done", int'(finished_pool), 0);
  endtask

  task automatic run_frame(input bit m);
    bit g;
    start_frame(m);
    send_pixels(NPIX, g);
    finish_frame();
  endtask

  task automatic bp_thread();
    bit f;
    f = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        f = 1'b1;
        break;
      end
    end
    chk("bp_seen", int'(f), 1);
    if (f) begin
      out_ready = 1'b0;
      repeat (10) begin
        @(negedge clk);
        chk("bp_in_ready", int'(in_ready), 0);
        chk("bp_data", int'($signed(out_data)), 2);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
    end
  endtask

  initial begin
    // Reset held with traffic offered: everything stays quiet
    reset    = 1'b0;
    enable   = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_last", int'(out_last), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_finished", int'(finished_pool), 0);
    end
    @(posedge clk); #1;
    reset  = 1'b1;
    enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("idle_in_ready", int'(in_ready), 0);
      chk("idle_out_valid", int'(out_valid), 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;

    // Average, free running digit frame
    fill_digit();
    push_expected(1'b0);
    run_frame(1'b0);

    // Average rounding corners
    fill_digit();
    set_win(0, -1, 0, 0, 0, -1);
    set_win(1, -128, -128, -128, -128, -128);
    set_win(2, 127, 127, 127, 127, 127);
    set_win(3, 1, 1, 1, 0, 0);
    push_expected(1'b0);
    run_frame(1'b0);

    // Max mode corners
    fill_digit();
    set_win(0, 3, -5, 7, 2, 7);
    set_win(1, -128, -100, -128, -128, -100);
    set_win(2, -1, -1, -1, -1, -1);
    push_expected(1'b1);
    run_frame(1'b1);

    // Stall the first result for 10 cycles
    fill_digit();
    push_expected(1'b0);
    rdy_mode  = 2;
    out_ready = 1'b1;
    start_frame(1'b0);
    fork
      send_pixels(NPIX, ok);
      bp_thread();
    join
    finish_frame();
    rdy_mode = 0;

    // Random out_ready over a whole frame
    rdy_mode = 1;
    fill_digit();
    push_expected(1'b0);
    run_frame(1'b0);
    rdy_mode = 0;
    @(posedge clk); #1;

    // Reset after 100 accepted pixels, then a fresh frame
    fill_digit();
    push_expected(1'b0);
    start_frame(1'b0);
    send_pixels(100, ok);
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_finished", int'(finished_pool), 0);
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    fill_digit();
    push_expected(1'b0);
    run_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
